// File: rtl/icmp_iter.sv
// Iterative chunked comparator: scans CW-bit chunks MSB-first and
// stops at the first differing chunk, behind valid/ready handshakes.
module icmp_iter #(
   parameter int BW = 32,
   parameter int CW = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [BW-1:0]                 a,
   input  logic [BW-1:0]                 b,
   input  logic [3:0]                    op,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          result,
   output logic                          err,
   output logic [$clog2(BW/CW+1)-1:0]    scans
);

   localparam int N  = BW / CW;
   localparam int SW = $clog2(N + 1);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SCAN = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [CW-1:0] MSB = CW'(1) << (CW - 1);

   generate
      if ((CW < 1) || (BW % CW != 0)) begin : g_bad
         $error("icmp_iter: BW must be a non-zero multiple of CW");
      end
   endgenerate

   logic [1:0]    state;
   logic [BW-1:0] ra;
   logic [BW-1:0] rb;
   logic [3:0]    rop;
   logic [IW-1:0] idx;

   logic [CW-1:0] ach [N];
   logic [CW-1:0] bch [N];

   for (genvar i = 0; i < N; i++) begin : g_chunk
      assign ach[i] = ra[i*CW +: CW];
      assign bch[i] = rb[i*CW +: CW];
   end

   logic          sgn;
   logic          top;
   logic [CW-1:0] ca;
   logic [CW-1:0] cb;
   logic          diff;
   logic          last;
   logic          lt;
   logic          eq;
   logic          gt;
   logic          bad;
   logic          pred;
   logic [SW-1:0] cnt;

   // Signed order equals unsigned order once the sign bits are flipped.
   assign sgn  = (rop >= 4'd2) && (rop <= 4'd5);
   assign top  = (idx == IW'(N - 1));
   assign ca   = ach[idx] ^ ((sgn && top) ? MSB : '0);
   assign cb   = bch[idx] ^ ((sgn && top) ? MSB : '0);
   assign diff = (ca != cb);
   assign last = (idx == '0);
   assign lt   = diff && (ca < cb);
   assign eq   = !diff;
   assign gt   = !eq && !lt;
   assign bad  = (rop > 4'd9);
   assign cnt  = SW'(N) - SW'(idx);

   always_comb begin
      pred = 1'b0;
      unique case (1'b1)
         (rop == 4'd0):                 pred = eq;
         (rop == 4'd1):                 pred = !eq;
         (rop == 4'd2), (rop == 4'd6):  pred = lt;
         (rop == 4'd3), (rop == 4'd7):  pred = lt | eq;
         (rop == 4'd4), (rop == 4'd8):  pred = gt;
         (rop == 4'd5), (rop == 4'd9):  pred = !lt;
         default:                       pred = 1'b0;
      endcase
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         ra     <= '0;
         rb     <= '0;
         rop    <= '0;
         idx    <= '0;
         result <= 1'b0;
         err    <= 1'b0;
         scans  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  ra    <= a;
                  rb    <= b;
                  rop   <= op;
                  idx   <= IW'(N - 1);
                  state <= SCAN;
               end
            end
            SCAN: begin
               if (diff || last) begin
                  result <= pred && !bad;
                  err    <= bad;
                  scans  <= cnt;
                  state  <= DONE;
               end else begin
                  idx <= idx - 1'b1;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_icmp_iter.sv
// Bench for icmp_iter: directed cases on a CW=8 instance, then a
// random sweep on CW=1/8/32 instances against a golden compare.
module tb_icmp_iter;

   localparam int NOPS = 3400;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic go = 1'b0;
   logic [2:0] fin = 3'b000;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic gold(input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] op);
      case (op)
         4'd0: return a == b;
         4'd1: return a != b;
         4'd2: return $signed(a) <  $signed(b);
         4'd3: return $signed(a) <= $signed(b);
         4'd4: return $signed(a) >  $signed(b);
         4'd5: return $signed(a) >= $signed(b);
         4'd6: return a <  b;
         4'd7: return a <= b;
         4'd8: return a >  b;
         4'd9: return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   function automatic int scn(input logic [31:0] a, input logic [31:0] b,
                              input int cw);
      logic [31:0] x;
      int hb;
      x  = a ^ b;
      hb = -1;
      for (int i = 0; i < 32; i++) if (x[i]) hb = i;
      if (hb < 0) return 32 / cw;
      return 32 / cw - hb / cw;
   endfunction

   // directed instance
   logic        div, dordy, d_ir, d_ov, d_res, d_err;
   logic [31:0] da, db;
   logic [3:0]  dop;
   logic [2:0]  d_sc;

   icmp_iter #(.BW(32), .CW(8)) u_dir (
      .clk(clk), .rst(rst),
      .in_valid(div), .in_ready(d_ir),
      .a(da), .b(db), .op(dop),
      .out_valid(d_ov), .out_ready(dordy),
      .result(d_res), .err(d_err), .scans(d_sc)
   );

   task automatic xact(input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic er,
                       input logic ee, input int es, input string tag);
      int w;
      int lat;
      @(negedge clk);
      da = a; db = b; dop = op; div = 1'b1; dordy = 1'b1;
      w = 0;
      while (!d_ir && w < 50) begin @(negedge clk); w++; end
      chk({tag, "_rdy"}, d_ir, 1);
      @(posedge clk); #1;
      div = 1'b0; da = ~a; db = $urandom; dop = 4'($urandom);
      lat = 0;
      while (!d_ov && lat <= 6) begin @(posedge clk); #1; lat++; end
      chk({tag, "_lat"}, lat, es);
      chk({tag, "_res"}, d_res, er);
      chk({tag, "_err"}, d_err, ee);
      chk({tag, "_scn"}, d_sc, es);
      @(posedge clk); #1;
      chk({tag, "_drn"}, d_ov, 0);
   endtask

   // random sweep instances
   for (genvar g = 0; g < 3; g++) begin : gr
      localparam int CWV = (g == 0) ? 1 : (g == 1) ? 8 : 32;
      localparam int NV  = 32 / CWV;
      localparam int SWV = $clog2(NV + 1);

      logic            iv, ordy, ir, ov, res, er;
      logic [31:0]     a, b;
      logic [3:0]      op;
      logic [SWV-1:0]  sc;

      icmp_iter #(.BW(32), .CW(CWV)) u (
         .clk(clk), .rst(rst),
         .in_valid(iv), .in_ready(ir),
         .a(a), .b(b), .op(op),
         .out_valid(ov), .out_ready(ordy),
         .result(res), .err(er), .scans(sc)
      );

      initial begin
         logic [31:0] xa, xb;
         logic [3:0]  xo;
         logic        rs_e, er_e;
         int          se, md, w, lat, hold;
         string       t;
         iv = 1'b0; ordy = 1'b0; a = '0; b = '0; op = '0;
         t = $sformatf("cw%0d", CWV);
         wait (go);
         for (int k = 0; k < NOPS; k++) begin
            xa = $urandom;
            md = $urandom_range(0, 7);
            if (md == 0)      xb = xa;
            else if (md <= 2) xb = xa ^ (32'd1 << $urandom_range(0, 31));
            else              xb = $urandom;
            if ($urandom_range(0, 19) == 0) xo = 4'($urandom_range(10, 15));
            else                            xo = 4'($urandom_range(0, 9));
            rs_e = gold(xa, xb, xo);
            er_e = (xo > 4'd9);
            se   = scn(xa, xb, CWV);
            @(negedge clk);
            a = xa; b = xb; op = xo; iv = 1'b1; ordy = 1'b0;
            w = 0;
            while (!ir && w < 50) begin @(negedge clk); w++; end
            chk({t, "_rdy"}, ir, 1);
            @(posedge clk); #1;
            iv = 1'b0; a = $urandom; b = $urandom; op = 4'($urandom);
            lat = 0;
            while (!ov && lat <= NV + 2) begin @(posedge clk); #1; lat++; end
            chk({t, "_lat"}, lat, se);
            chk({t, "_res"}, res, rs_e);
            chk({t, "_err"}, er, er_e);
            chk({t, "_scn"}, sc, se);
            hold = $urandom_range(0, 3);
            repeat (hold) begin
               @(negedge clk);
               chk({t, "_hold"}, {ov, er, res}, {1'b1, er_e, rs_e});
            end
            @(negedge clk); ordy = 1'b1;
            @(posedge clk); #1; ordy = 1'b0;
            chk({t, "_drn"}, ov, 0);
         end
         fin[g] = 1'b1;
      end
   end

   initial begin
      int t;
      div = 1'b0; dordy = 1'b0; da = '0; db = '0; dop = '0;
      #12;
      chk("rst_ir",  d_ir, 1);
      chk("rst_ov",  d_ov, 0);
      chk("rst_res", d_res, 0);
      chk("rst_err", d_err, 0);
      chk("rst_scn", d_sc, 0);
      @(negedge clk); rst = 1'b0;
      #1;
      chk("rel_ir", d_ir, 1);

      xact(32'h12345678, 32'h12345678, 4'd0, 1'b1, 1'b0, 4, "eq");
      xact(32'h12345678, 32'h12345678, 4'd1, 1'b0, 1'b0, 4, "ne");
      xact(32'h80000000, 32'h00000001, 4'd2, 1'b1, 1'b0, 1, "slt");
      xact(32'h80000000, 32'h00000001, 4'd6, 1'b0, 1'b0, 1, "ult");
      xact(32'h12345600, 32'h12345601, 4'd7, 1'b1, 1'b0, 4, "ule");
      xact(32'h12345600, 32'h12345601, 4'd8, 1'b0, 1'b0, 4, "ugt");
      xact(32'h12345600, 32'h12345601, 4'd5, 1'b0, 1'b0, 4, "sge");
      xact(32'hdeadbeef, 32'hdeadbeef, 4'd12, 1'b0, 1'b1, 4, "ill");

      // backpressure: result held, new request ignored
      @(negedge clk);
      da = 32'h12345600; db = 32'h12345601; dop = 4'd7;
      div = 1'b1; dordy = 1'b0;
      @(posedge clk); #1; div = 1'b0;
      t = 0;
      while (!d_ov && t < 10) begin @(posedge clk); #1; t++; end
      chk("bp_lat", t, 4);
      @(negedge clk);
      div = 1'b1; da = '0; db = '0; dop = 4'd0;
      repeat (5) begin
         @(negedge clk);
         chk("bp_hold", {d_ov, d_ir, d_res, d_err}, 4'b1010);
         chk("bp_scn", d_sc, 4);
      end
      div = 1'b0; dordy = 1'b1;
      @(posedge clk); #1;
      chk("bp_drn", {d_ov, d_ir}, 2'b01);
      repeat (3) begin
         @(posedge clk); #1;
         chk("bp_idle", d_ov, 0);
      end

      // reset in the middle of a scan
      @(negedge clk);
      da = 32'h0000abcd; db = 32'h0000abce; dop = 4'd0; div = 1'b1;
      @(posedge clk); #1; div = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("mrst_ov", d_ov, 0);
      chk("mrst_scn", d_sc, 0);
      @(negedge clk); rst = 1'b0;
      #1;
      chk("mrst_ir", d_ir, 1);
      repeat (6) begin
         @(posedge clk); #1;
         chk("mrst_idle", d_ov, 0);
      end

      go = 1'b1;
      t = 0;
      while (fin != 3'b111 && t < 80000) begin @(posedge clk); t++; end
      chk("sweep_done", fin, 3'b111);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
